// File: rtl/iob_merge_arbiter_pkg.sv
// Shared types and helpers for the iob_merge round-robin arbiter.
// Holds the FSM state encoding, the outstanding-read counter width and the round-robin index helper.
package iob_merge_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    // Index visited at step k (1..n) of a scan that starts just after 'last'.
    function automatic int unsigned rr_pos(input int unsigned last, input int unsigned k,
                                           input int unsigned n);
        return (last + k) % n;
    endfunction

endpackage

// File: rtl/iob_merge_arbiter_rr_prio.sv
// Combinational round-robin picker: first requester after 'last', wrapping through all N.
// A lone request from 'last' itself is still granted because the scan ends on 'last'.
module iob_rr_prio
    import iob_merge_arbiter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned NB = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [NB-1:0] last_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [NB-1:0] gnt_idx_o
);

    always_comb begin : p_rr
        logic          found;
        logic [NB-1:0] idx;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = NB'(rr_pos(32'(last_i), k, N));
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_idx_o     = idx;
            end
        end
    end

endmodule

// File: rtl/iob_merge_arbiter.sv
// Round-robin arbiter driving iob_merge's master select; holds a grant until the
// master's burst ends and all its outstanding reads have returned.
module iob_merge_arbiter
    import iob_merge_arbiter_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned NB      = $clog2(N),
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_n_i,
    input  logic [N-1:0]        m_avalid_i,
    input  logic                f_avalid_i,
    input  logic [DATA_W/8-1:0] f_wstrb_i,
    input  logic                f_ready_i,
    input  logic                f_rvalid_i,
    output logic [N-1:0]        m_sel_src_o,
    output logic [NB-1:0]       m_sel_o,
    output logic                busy_o,
    output logic                ovf_o
);

    localparam int unsigned CW      = cnt_width(MAX_OUT);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NB-1:0] last_q, last_d;
    logic [NB-1:0] sel_q, sel_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          ovf_q, ovf_d;

    logic          rd_acc;
    logic [N-1:0]  win_oh;
    logic [NB-1:0] win_idx;

    iob_rr_prio #(
        .N  (N),
        .NB (NB)
    ) u_rr_prio (
        .req_i     (m_avalid_i),
        .last_i    (last_q),
        .gnt_oh_o  (win_oh),
        .gnt_idx_o (win_idx)
    );

    assign rd_acc = f_avalid_i & f_ready_i & ~(|f_wstrb_i);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (rd_acc && !f_rvalid_i) begin
            if (cnt_q == MAX_CNT) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end else if (!rd_acc && f_rvalid_i) begin
            if (cnt_q == '0) ovf_d = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    // Release looks at the next counter value so a same-cycle final rvalid frees the grant.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (|m_avalid_i) begin
                    gnt_d   = win_oh;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (!(|(m_avalid_i & gnt_q)) && (cnt_d == '0)) begin
                    if (|m_avalid_i) begin
                        gnt_d  = win_oh;
                        sel_d  = win_idx;
                        last_d = win_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= NB'(N - 1);
            sel_q   <= '0;
            gnt_q   <= N'(1);
            ovf_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign m_sel_src_o = gnt_q;
    assign m_sel_o     = sel_q;
    assign busy_o      = (state_q == LOCK);
    assign ovf_o       = ovf_q;

endmodule
